// File: rtl/spi_accel_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_accel_responder
// Purpose  : SPI mode-3 responder emulating an ADXL345-style register map
//            (device ID, two R/W config registers, six RO sample bytes).
//            All SPI pins are oversampled in the clk domain.
// Revision : 1.0
// ============================================================================
module spi_accel_responder #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_csn,
  input  logic        spi_sclk,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        spi_sdo_oe,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic [7:0]  power_ctl,
  output logic [7:0]  data_format,
  output logic        xact_done
);

  localparam logic [5:0] ADDR_DEVID  = 6'h00;
  localparam logic [5:0] ADDR_PWR    = 6'h2D;
  localparam logic [5:0] ADDR_FMT    = 6'h31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] csn_sync, sclk_sync, sdi_sync;
  logic        csn_d, sclk_d;
  logic        csn_s, sclk_s, sdi_s;
  logic        csn_fall, csn_rise, sclk_rise, sclk_fall;

  logic [15:0] live_x, live_y, live_z;
  logic [15:0] shad_x, shad_y, shad_z;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_shift;
  logic [7:0]  tx_shift;
  logic [5:0]  addr;
  logic        rw, mb;
  logic        byte_seen;
  logic [7:0]  rx_byte;

  // Synchronizer chains; csn/sclk reset to their idle-high levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csn_sync  <= '1;
      sclk_sync <= '1;
      sdi_sync  <= '0;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0],  spi_csn};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0],  spi_sdi};
    end
  end

  assign csn_s  = csn_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync[SYNC_STAGES-1];

  // One-flop history for edge detection on the synchronized pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csn_d  <= 1'b1;
      sclk_d <= 1'b1;
    end else begin
      csn_d  <= csn_s;
      sclk_d <= sclk_s;
    end
  end

  assign csn_fall  =  csn_d  & ~csn_s;
  assign csn_rise  = ~csn_d  &  csn_s;
  assign sclk_rise = ~sclk_d &  sclk_s & ~csn_s;
  assign sclk_fall =  sclk_d & ~sclk_s & ~csn_s;

  // Live sample registers follow every strobe, even mid-transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_x <= '0;
      live_y <= '0;
      live_z <= '0;
    end else if (sample_valid) begin
      live_x <= sample_x;
      live_y <= sample_y;
      live_z <= sample_z;
    end
  end

  // Register read mux; sample bytes come from the frozen shadow copy
  function automatic logic [7:0] reg_read(input logic [5:0] a);
    case (a)
      ADDR_DEVID: reg_read = DEVID;
      ADDR_PWR:   reg_read = power_ctl;
      ADDR_FMT:   reg_read = data_format;
      6'h32:      reg_read = shad_x[7:0];
      6'h33:      reg_read = shad_x[15:8];
      6'h34:      reg_read = shad_y[7:0];
      6'h35:      reg_read = shad_y[15:8];
      6'h36:      reg_read = shad_z[7:0];
      6'h37:      reg_read = shad_z[15:8];
      default:    reg_read = 8'h00;
    endcase
  endfunction

  assign rx_byte = {rx_shift, sdi_s};

  // Transaction FSM: command decode, read shifting, register writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      addr        <= '0;
      rw          <= 1'b0;
      mb          <= 1'b0;
      byte_seen   <= 1'b0;
      shad_x      <= '0;
      shad_y      <= '0;
      shad_z      <= '0;
      power_ctl   <= '0;
      data_format <= '0;
      xact_done   <= 1'b0;
    end else begin
      xact_done <= 1'b0;
      if (csn_rise) begin
        // Partial byte is simply dropped; only completed bytes count
        xact_done <= (state != IDLE) && byte_seen;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (csn_fall) begin
              state     <= CMD;
              bit_cnt   <= '0;
              byte_seen <= 1'b0;
              tx_shift  <= '0;
              shad_x    <= sample_valid ? sample_x : live_x;
              shad_y    <= sample_valid ? sample_y : live_y;
              shad_z    <= sample_valid ? sample_z : live_z;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[5:0], sdi_s};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw        <= rx_shift[6];
                mb        <= rx_shift[5];
                addr      <= rx_byte[5:0];
                byte_seen <= 1'b1;
                state     <= DATA;
              end
            end
          end
          DATA: begin
            if (sclk_fall && rw) begin
              tx_shift <= (bit_cnt == 3'd0) ? reg_read(addr) : {tx_shift[6:0], 1'b0};
            end
            if (sclk_rise) begin
              rx_shift <= {rx_shift[5:0], sdi_s};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (!rw) begin
                  if (addr == ADDR_PWR) power_ctl   <= rx_byte;
                  if (addr == ADDR_FMT) data_format <= rx_byte;
                end
                if (mb) addr <= addr + 6'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign spi_sdo_oe = (state == DATA) && rw && !csn_s;
  assign spi_sdo    = spi_sdo_oe & tx_shift[7];

endmodule
`default_nettype wire

// File: tb/tb_spi_accel_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_accel_responder
// Purpose  : Directed self-checking bench for spi_accel_responder
// Revision : 1.0
// ============================================================================
module tb_spi_accel_responder;

  localparam int HALF = 8;   // SCLK half period in clk cycles

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_csn, spi_sclk, spi_sdi;
  logic        spi_sdo, spi_sdo_oe;
  logic [15:0] sample_x, sample_y, sample_z;
  logic        sample_valid;
  logic [7:0]  power_ctl, data_format;
  logic        xact_done;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;

  spi_accel_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_csn      (spi_csn),
    .spi_sclk     (spi_sclk),
    .spi_sdi      (spi_sdi),
    .spi_sdo      (spi_sdo),
    .spi_sdo_oe   (spi_sdo_oe),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .sample_valid (sample_valid),
    .power_ctl    (power_ctl),
    .data_format  (data_format),
    .xact_done    (xact_done)
  );

  always #5 clk = ~clk;

  // Count xact_done pulses, sampled mid-cycle
  always @(negedge clk) if (xact_done === 1'b1) done_cnt++;

  task automatic csn_low();
    spi_csn = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic csn_high();
    repeat (HALF) @(negedge clk);
    spi_csn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Mode-3 initiator: drive on falling edge, sample sdo just before rising edge
  task automatic spi_bits(input logic [7:0] tx, input int n,
                          output logic [7:0] rx, output logic oe_all, output logic oe_any);
    rx = 8'h00; oe_all = 1'b1; oe_any = 1'b0;
    for (int i = 0; i < n; i++) begin
      spi_sclk = 1'b0;
      spi_sdi  = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx[7-i] = spi_sdo;
      oe_all  = oe_all & spi_sdo_oe;
      oe_any  = oe_any | spi_sdo_oe;
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_x = x; sample_y = y; sample_z = z; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; spi_csn = 1'b1; spi_sclk = 1'b1; spi_sdi = 1'b0;
    sample_x = '0; sample_y = '0; sample_z = '0; sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++;
    if ({power_ctl, data_format, spi_sdo, spi_sdo_oe, xact_done} !== 19'd0)
      $display("FAIL reset_outputs: got pwr=%h fmt=%h sdo=%b oe=%b done=%b, want all 0",
               power_ctl, data_format, spi_sdo, spi_sdo_oe, xact_done);
    else pass_cnt++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_devid();
    logic [7:0] rx; logic oa, on;
    int d0;
    d0 = done_cnt;
    csn_low();
    spi_bits(8'h80, 8, rx, oa, on);
    total_cnt++;
    if (on !== 1'b0) $display("FAIL devid_cmd_oe: got oe_any=%b, want 0", on); else pass_cnt++;
    spi_bits(8'h00, 8, rx, oa, on);
    total_cnt++;
    if (rx !== 8'hE5) $display("FAIL devid_data: got %h, want e5", rx); else pass_cnt++;
    total_cnt++;
    if (oa !== 1'b1) $display("FAIL devid_data_oe: got oe_all=%b, want 1", oa); else pass_cnt++;
    csn_high();
    total_cnt++;
    if (spi_sdo_oe !== 1'b0) $display("FAIL devid_oe_after: got %b, want 0", spi_sdo_oe); else pass_cnt++;
    total_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL devid_done: got %0d pulses, want 1", done_cnt - d0); else pass_cnt++;
    total_cnt++;
    if (power_ctl !== 8'h00) $display("FAIL devid_pwr: got %h, want 00", power_ctl); else pass_cnt++;
  endtask

  task automatic test_write_pwr();
    logic [7:0] rx; logic oa, on;
    int d0;
    d0 = done_cnt;
    csn_low();
    spi_bits(8'h2D, 8, rx, oa, on);
    spi_bits(8'h08, 8, rx, oa, on);
    total_cnt++;
    if (power_ctl !== 8'h08) $display("FAIL write_pwr: got %h, want 08", power_ctl); else pass_cnt++;
    total_cnt++;
    if (on !== 1'b0) $display("FAIL write_oe: got oe_any=%b, want 0", on); else pass_cnt++;
    csn_high();
    total_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL write_done: got %0d pulses, want 1", done_cnt - d0); else pass_cnt++;
    csn_low();
    spi_bits(8'hAD, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    csn_high();
    total_cnt++;
    if (rx !== 8'h08) $display("FAIL readback_pwr: got %h, want 08", rx); else pass_cnt++;
  endtask

  task automatic test_burst_read();
    logic [7:0] rx; logic oa, on;
    logic [7:0] exp_a [6];
    logic [7:0] exp_b [6];
    exp_a = '{8'hFF, 8'h01, 8'h80, 8'hFF, 8'h00, 8'h01};
    exp_b = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    strobe(16'h01FF, 16'hFF80, 16'h0100);
    repeat (4) @(negedge clk);
    csn_low();
    spi_bits(8'hF2, 8, rx, oa, on);
    for (int i = 0; i < 6; i++) begin
      spi_bits(8'h00, 8, rx, oa, on);
      total_cnt++;
      if (rx !== exp_a[i]) $display("FAIL burst_byte%0d: got %h, want %h", i, rx, exp_a[i]);
      else pass_cnt++;
    end
    csn_high();
    // Coherency: new samples mid-burst must not leak into this burst
    csn_low();
    spi_bits(8'hF2, 8, rx, oa, on);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) strobe(16'h1234, 16'h5678, 16'h9ABC);
      spi_bits(8'h00, 8, rx, oa, on);
      total_cnt++;
      if (rx !== exp_a[i]) $display("FAIL coherent_byte%0d: got %h, want %h", i, rx, exp_a[i]);
      else pass_cnt++;
    end
    csn_high();
    csn_low();
    spi_bits(8'hF2, 8, rx, oa, on);
    for (int i = 0; i < 6; i++) begin
      spi_bits(8'h00, 8, rx, oa, on);
      total_cnt++;
      if (rx !== exp_b[i]) $display("FAIL new_sample_byte%0d: got %h, want %h", i, rx, exp_b[i]);
      else pass_cnt++;
    end
    csn_high();
  endtask

  task automatic test_partial_write();
    logic [7:0] rx; logic oa, on;
    int d0;
    d0 = done_cnt;
    csn_low();
    spi_bits(8'h31, 8, rx, oa, on);
    spi_bits(8'h0B, 5, rx, oa, on);
    csn_high();
    total_cnt++;
    if (data_format !== 8'h00) $display("FAIL partial_write: got %h, want 00", data_format); else pass_cnt++;
    total_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL partial_done: got %0d pulses, want 1", done_cnt - d0); else pass_cnt++;
    csn_low();
    spi_bits(8'h31, 8, rx, oa, on);
    spi_bits(8'h0B, 8, rx, oa, on);
    csn_high();
    total_cnt++;
    if (data_format !== 8'h0B) $display("FAIL full_write_fmt: got %h, want 0b", data_format); else pass_cnt++;
  endtask

  task automatic test_wrap_and_ro();
    logic [7:0] rx; logic oa, on;
    csn_low();
    spi_bits(8'hFF, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    total_cnt++;
    if (rx !== 8'h00) $display("FAIL wrap_3f: got %h, want 00", rx); else pass_cnt++;
    spi_bits(8'h00, 8, rx, oa, on);
    total_cnt++;
    if (rx !== 8'hE5) $display("FAIL wrap_00: got %h, want e5", rx); else pass_cnt++;
    csn_high();
    csn_low();
    spi_bits(8'h32, 8, rx, oa, on);
    spi_bits(8'hAA, 8, rx, oa, on);
    csn_high();
    csn_low();
    spi_bits(8'hB2, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    total_cnt++;
    if (rx !== 8'h34) $display("FAIL ro_write_ignored: got %h, want 34", rx); else pass_cnt++;
    // Without MB the same register repeats
    spi_bits(8'h00, 8, rx, oa, on);
    total_cnt++;
    if (rx !== 8'h34) $display("FAIL no_mb_repeat: got %h, want 34", rx); else pass_cnt++;
    csn_high();
    total_cnt++;
    if (power_ctl !== 8'h08 || data_format !== 8'h0B)
      $display("FAIL cfg_kept: got pwr=%h fmt=%h, want 08 0b", power_ctl, data_format);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_devid();
    test_write_pwr();
    test_burst_read();
    test_partial_write();
    test_wrap_and_ro();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
